// File: rtl/ascon_pack.sv
// Shared types and round-count constants for the ASCON-128 control FSM.
package ascon_pack;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_AD,
    AD,
    WAIT_PT,
    PT,
    FINAL,
    DONE
  } state_t;

  localparam logic [3:0] P12_START  = 4'd0;
  localparam logic [3:0] P6_START   = 4'd6;
  localparam logic [3:0] LAST_ROUND = 4'd11;

endpackage

// File: rtl/round_counter.sv
// 4-bit permutation round counter: loadable start value, saturates at the last round.
module round_counter
  import ascon_pack::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       enable,
  output logic [3:0] count
);

  // Saturating so the final round index stays visible while the FSM waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != LAST_ROUND)) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 encryption sequencer: schedules p12/p6 permutation rounds and XOR controls.
module ascon_ctrl_fsm
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       last_block_i,
  output logic       data_ready_o,
  output logic       select_o,
  output logic       enable_o,
  output logic [3:0] round_o,
  output logic       xor_data_begin_o,
  output logic       xor_key_begin_o,
  output logic       xor_key_end_o,
  output logic       xor_ext_end_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  state_t     state;
  state_t     state_next;
  logic       cnt_load;
  logic [3:0] cnt_load_value;
  logic [3:0] round;
  logic       last_round;

  assign last_round = (round == LAST_ROUND);
  assign round_o    = round;

  round_counter u_round_counter (
    .clk        (clock_i),
    .rst_n      (reset_i),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .enable     (enable_o),
    .count      (round)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The counter is preloaded on the transition into each permutation phase.
  always_comb begin
    state_next     = state;
    cnt_load       = 1'b0;
    cnt_load_value = P6_START;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next     = INIT;
          cnt_load       = 1'b1;
          cnt_load_value = P12_START;
        end
      end
      INIT:    if (last_round) state_next = WAIT_AD;
      WAIT_AD: begin
        if (data_valid_i) begin
          state_next = AD;
          cnt_load   = 1'b1;
        end
      end
      AD:      if (last_round) state_next = WAIT_PT;
      WAIT_PT: begin
        if (data_valid_i) begin
          cnt_load = 1'b1;
          if (last_block_i) begin
            state_next     = FINAL;
            cnt_load_value = P12_START;
          end else begin
            state_next = PT;
          end
        end
      end
      PT:      if (last_round) state_next = WAIT_PT;
      FINAL:   if (last_round) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore output decode; IDLE keeps select low so reset and idle look identical.
  always_comb begin
    data_ready_o     = 1'b0;
    select_o         = 1'b1;
    enable_o         = 1'b0;
    xor_data_begin_o = 1'b0;
    xor_key_begin_o  = 1'b0;
    xor_key_end_o    = 1'b0;
    xor_ext_end_o    = 1'b0;
    cipher_valid_o   = 1'b0;
    tag_valid_o      = 1'b0;
    busy_o           = (state != IDLE);
    case (state)
      IDLE: select_o = 1'b0;
      INIT: begin
        enable_o      = 1'b1;
        select_o      = (round != P12_START);
        xor_key_end_o = last_round;
      end
      WAIT_AD, WAIT_PT: data_ready_o = 1'b1;
      AD: begin
        enable_o         = 1'b1;
        xor_data_begin_o = (round == P6_START);
        xor_ext_end_o    = last_round;
      end
      PT: begin
        enable_o         = 1'b1;
        xor_data_begin_o = (round == P6_START);
        cipher_valid_o   = (round == P6_START);
      end
      FINAL: begin
        enable_o         = 1'b1;
        xor_data_begin_o = (round == P12_START);
        xor_key_begin_o  = (round == P12_START);
        cipher_valid_o   = (round == P12_START);
        xor_key_end_o    = last_round;
      end
      DONE:    tag_valid_o = 1'b1;
      default: select_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Randomized bench for ascon_ctrl_fsm: phase-level reference timeline feeding an event scoreboard.
module tb_ascon_ctrl_fsm;

  typedef struct packed {
    logic       ready;
    logic       en;
    logic       sel;
    logic       xdb;
    logic       xkb;
    logic       xke;
    logic       xee;
    logic       cv;
    logic       tv;
    logic       busy;
    logic [3:0] rnd;
  } vec_t;

  typedef struct {
    int   cyc;
    vec_t v;
  } ev_t;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       start_i = 1'b0;
  logic       data_valid_i = 1'b0;
  logic       last_block_i = 1'b0;
  logic       data_ready_o, select_o, enable_o;
  logic [3:0] round_o;
  logic       xor_data_begin_o, xor_key_begin_o, xor_key_end_o, xor_ext_end_o;
  logic       cipher_valid_o, tag_valid_o, busy_o;

  int   cyc = 0;
  int   tag_cyc = -1;
  int   checks = 0;
  int   failures = 0;
  vec_t tl[$];
  bit   acc[$];
  bit   lst[$];
  ev_t  sb[$];
  int   wait_sum;

  ascon_ctrl_fsm dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .start_i          (start_i),
    .data_valid_i     (data_valid_i),
    .last_block_i     (last_block_i),
    .data_ready_o     (data_ready_o),
    .select_o         (select_o),
    .enable_o         (enable_o),
    .round_o          (round_o),
    .xor_data_begin_o (xor_data_begin_o),
    .xor_key_begin_o  (xor_key_begin_o),
    .xor_key_end_o    (xor_key_end_o),
    .xor_ext_end_o    (xor_ext_end_o),
    .cipher_valid_o   (cipher_valid_o),
    .tag_valid_o      (tag_valid_o),
    .busy_o           (busy_o)
  );

  always #5 clock_i = ~clock_i;

  always @(posedge clock_i) cyc <= cyc + 1;

  function automatic vec_t dutVec();
    vec_t v;
    v.ready = data_ready_o;   v.en  = enable_o;        v.sel = select_o;
    v.xdb   = xor_data_begin_o; v.xkb = xor_key_begin_o; v.xke = xor_key_end_o;
    v.xee   = xor_ext_end_o;  v.cv  = cipher_valid_o;  v.tv  = tag_valid_o;
    v.busy  = busy_o;         v.rnd = round_o;
    return v;
  endfunction

  function automatic bit isMarker(vec_t v);
    return v.ready | v.cv | v.tv | v.xdb | v.xkb | v.xke | v.xee | (v.busy & ~v.sel);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic addCycle(input vec_t v, input bit a, input bit l);
    tl.push_back(v);
    acc.push_back(a);
    lst.push_back(l);
  endtask

  // A permutation phase of rounds first..11 with XOR/valid strobes at given rounds.
  task automatic addRounds(input int first, input int sel0_at, input int xdb_at, input int xkb_at,
                           input int xke_at, input int xee_at, input int cv_at);
    vec_t v;
    for (int r = first; r <= 11; r++) begin
      v = '0;
      v.en = 1'b1; v.busy = 1'b1; v.rnd = 4'(r);
      v.sel = (r != sel0_at);
      v.xdb = (r == xdb_at); v.xkb = (r == xkb_at); v.xke = (r == xke_at);
      v.xee = (r == xee_at); v.cv  = (r == cv_at);
      addCycle(v, 1'b0, 1'b0);
    end
  endtask

  task automatic addWait(input int w, input bit is_last);
    vec_t v;
    v = '0;
    v.ready = 1'b1; v.sel = 1'b1; v.busy = 1'b1; v.rnd = 4'd11;
    for (int j = 0; j <= w; j++) addCycle(v, (j == w), is_last);
    wait_sum += w;
  endtask

  // Expected cycle-by-cycle behaviour of one encryption, index 0 = the start cycle.
  task automatic buildTimeline(input int n, input int ad_wait, input int pt_wait);
    vec_t v;
    tl.delete(); acc.delete(); lst.delete();
    wait_sum = 0;
    addCycle('0, 1'b0, 1'b0);
    addRounds(0, 0, -1, -1, 11, -1, -1);
    addWait(ad_wait, 1'b0);
    addRounds(6, -1, 6, -1, -1, 11, -1);
    for (int i = 0; i < n; i++) begin
      addWait((pt_wait >= 0) ? pt_wait : int'($urandom_range(0, 3)), (i == n - 1));
      if (i == n - 1) addRounds(0, -1, 0, 0, 11, -1, 0);
      else            addRounds(6, -1, 6, -1, -1, -1, 6);
    end
    v = '0;
    v.tv = 1'b1; v.sel = 1'b1; v.busy = 1'b1; v.rnd = 4'd11;
    addCycle(v, 1'b0, 1'b0);
  endtask

  task automatic applyStimulus(input int n, input int ad_wait, input int pt_wait, input bit abort);
    int   base;
    int   abort_at;
    int   exp_lat;
    int   abort_cyc;
    ev_t  e;
    buildTimeline(n, ad_wait, pt_wait);
    abort_at = abort ? (tl.size() - 9) : -1;
    exp_lat  = 12 + 1 + 6 + 6 * (n - 1) + (n - 1) + 1 + 12 + 1 + wait_sum;
    @(posedge clock_i); #1;
    base = cyc;
    for (int k = 1; k < tl.size(); k++) begin
      if (isMarker(tl[k])) begin
        e.cyc = base + k;
        e.v   = tl[k];
        sb.push_back(e);
      end
    end
    start_i      = 1'b1;
    data_valid_i = 1'($urandom);
    last_block_i = 1'($urandom);
    for (int k = 1; k < tl.size(); k++) begin
      @(posedge clock_i); #1;
      if (k == abort_at) begin
        checkOutput("abort_point_round", round_o, 4);
        #3 reset_i = 1'b0;
        #1 checkOutput("abort_outputs", dutVec(), 0);
        abort_cyc = cyc;
        sb.delete();
        start_i = 1'b0; data_valid_i = 1'b0; last_block_i = 1'b0;
        repeat (2) @(posedge clock_i);
        @(negedge clock_i) reset_i = 1'b1;
        repeat (20) @(posedge clock_i);
        #1 checkOutput("no_tag_after_abort", int'(tag_cyc >= abort_cyc), 0);
        checkOutput("idle_after_abort", busy_o, 0);
        return;
      end
      start_i = 1'($urandom);
      if (tl[k].ready) begin
        data_valid_i = acc[k];
        last_block_i = acc[k] ? lst[k] : 1'($urandom);
      end else begin
        data_valid_i = 1'($urandom);
        last_block_i = 1'($urandom);
      end
    end
    @(posedge clock_i); #1;
    start_i = 1'b0; data_valid_i = 1'b0; last_block_i = 1'b0;
    checkOutput("tag_latency", tag_cyc - base, exp_lat);
    checkOutput("idle_after_tag", busy_o, 0);
    checkOutput("scoreboard_drained", sb.size(), 0);
  endtask

  // Monitor: every marker cycle on the DUT pops one expected event.
  always begin
    ev_t e;
    vec_t d;
    @(posedge clock_i); #1;
    if (reset_i) begin
      d = dutVec();
      if (d.tv) tag_cyc = cyc;
      if (isMarker(d)) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_event", d, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("event_cycle", cyc, e.cyc);
          checkOutput("event_outputs", d, e.v);
        end
      end
    end
  end

  initial begin
    #20 checkOutput("in_reset_outputs", dutVec(), 0);
    #5 reset_i = 1'b1;
    @(negedge clock_i) checkOutput("post_reset_outputs", dutVec(), 0);
    repeat (2) @(posedge clock_i);

    applyStimulus(2, 0, 0, 1'b0);
    applyStimulus(2, 2, 5, 1'b0);
    applyStimulus(1, 0, 0, 1'b0);
    for (int t = 0; t < 6; t++)
      applyStimulus(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), -1, 1'b0);
    applyStimulus(3, 1, -1, 1'b1);
    applyStimulus(2, 0, 0, 1'b0);

    repeat (3) @(posedge clock_i);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
